// File: rtl/ddr_write_splitter.sv
// ddr_write_splitter: splits one DDR write job into CHUNK_BYTES-aligned chunk
// requests, forwards the job data stream with a per-chunk last flag, tracks
// outstanding chunk responses and reports one completion (with sticky error)
// per job.
module ddr_write_splitter #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int SIZE_WIDTH      = 16,
  parameter int LEN_WIDTH       = 32,
  parameter int CHUNK_BYTES     = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [ADDR_WIDTH-1:0] job_addr,
  input  logic [LEN_WIDTH-1:0]  job_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  done_valid,
  output logic                  done_err,
  output logic                  ddr_wreq_valid,
  input  logic                  ddr_wreq_ready,
  output logic [ADDR_WIDTH-1:0] ddr_wreq_addr,
  output logic [SIZE_WIDTH-1:0] ddr_wreq_size,
  output logic                  ddr_wdata_valid,
  input  logic                  ddr_wdata_ready,
  output logic                  ddr_wdata_last,
  output logic [DATA_WIDTH-1:0] ddr_wdata,
  input  logic                  ddr_wresp_valid,
  input  logic [1:0]            ddr_wresp
);

  localparam int BPB    = DATA_WIDTH / 8;
  localparam int BPB_LG = $clog2(BPB);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(BPB - 1));
  localparam logic [LEN_WIDTH-1:0]  LEN_MASK  = ~(LEN_WIDTH'(BPB - 1));
  localparam logic [OUT_W-1:0]      OUT_MAX   = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_DATA  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Bytes of the next chunk: the remaining length, clipped at the next chunk boundary.
  function automatic logic [SIZE_WIDTH-1:0] chunk_size(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [LEN_WIDTH-1:0]  rem);
    logic [LEN_WIDTH-1:0] room;
    room = LEN_WIDTH'(CHUNK_BYTES) - LEN_WIDTH'(addr & ADDR_WIDTH'(CHUNK_BYTES - 1));
    chunk_size = (rem < room) ? SIZE_WIDTH'(rem) : SIZE_WIDTH'(room);
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic                  err_q, err_d;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;
  logic [SIZE_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                  wreq_valid_q, wreq_valid_d;
  logic [ADDR_WIDTH-1:0] wreq_addr_q, wreq_addr_d;
  logic [SIZE_WIDTH-1:0] wreq_size_q, wreq_size_d;
  logic                  done_valid_q, done_err_q;

  logic                  req_hs_s;
  logic                  resp_take_s;
  logic [SIZE_WIDTH-1:0] beats_m1_s;
  logic [LEN_WIDTH-1:0]  remain_left_s;
  logic [ADDR_WIDTH-1:0] job_addr_s;
  logic [LEN_WIDTH-1:0]  job_len_s;

  assign ddr_wreq_valid = wreq_valid_q;
  assign ddr_wreq_addr  = wreq_addr_q;
  assign ddr_wreq_size  = wreq_size_q;
  assign done_valid     = done_valid_q;
  assign done_err       = done_err_q;
  assign ddr_wdata      = in_data;

  // Next-state, counters, request register inputs and the data pass-through handshake.
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remain_d      = remain_q;
    err_d         = err_q;
    beat_cnt_d    = beat_cnt_q;
    wreq_valid_d  = wreq_valid_q;
    wreq_addr_d   = wreq_addr_q;
    wreq_size_d   = wreq_size_q;
    job_ready     = 1'b0;
    in_ready      = 1'b0;
    ddr_wdata_valid = 1'b0;
    ddr_wdata_last  = 1'b0;

    job_addr_s    = job_addr & ADDR_MASK;
    job_len_s     = job_len & LEN_MASK;
    req_hs_s      = wreq_valid_q & ddr_wreq_ready;
    // A response with nothing outstanding is a stray (e.g. after reset) and is dropped.
    resp_take_s   = ddr_wresp_valid & (outstanding_q != {OUT_W{1'b0}});
    outstanding_d = outstanding_q + OUT_W'(req_hs_s) - OUT_W'(resp_take_s);
    beats_m1_s    = (wreq_size_q >> BPB_LG) - SIZE_WIDTH'(1);
    remain_left_s = remain_q - LEN_WIDTH'(wreq_size_q);

    if (resp_take_s && (ddr_wresp != 2'd0)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          cur_addr_d = job_addr_s;
          remain_d   = job_len_s;
          err_d      = 1'b0;
          if (job_len_s == {LEN_WIDTH{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            // First request goes out the cycle right after the job is accepted.
            state_d      = S_REQ;
            wreq_valid_d = 1'b1;
            wreq_addr_d  = job_addr_s;
            wreq_size_d  = chunk_size(job_addr_s, job_len_s);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (wreq_valid_q) begin
          if (ddr_wreq_ready) begin
            wreq_valid_d = 1'b0;
            beat_cnt_d   = {SIZE_WIDTH{1'b0}};
            state_d      = S_DATA;
          end else begin
            wreq_valid_d = 1'b1;
          end
        end else if (outstanding_q < OUT_MAX) begin
          wreq_valid_d = 1'b1;
          wreq_addr_d  = cur_addr_q;
          wreq_size_d  = chunk_size(cur_addr_q, remain_q);
        end else begin
          wreq_valid_d = 1'b0;
        end
      end
      S_DATA: begin
        ddr_wdata_valid = in_valid;
        in_ready        = ddr_wdata_ready;
        ddr_wdata_last  = (beat_cnt_q == beats_m1_s);
        if (in_valid && ddr_wdata_ready) begin
          if (beat_cnt_q == beats_m1_s) begin
            cur_addr_d = cur_addr_q + ADDR_WIDTH'(wreq_size_q);
            remain_d   = remain_left_s;
            state_d    = (remain_left_s == {LEN_WIDTH{1'b0}}) ? S_DRAIN : S_REQ;
          end else begin
            beat_cnt_d = beat_cnt_q + SIZE_WIDTH'(1);
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      S_DRAIN: begin
        // Leave as soon as the final response has been counted.
        if (outstanding_d == {OUT_W{1'b0}}) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; completion is flagged the cycle after DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      cur_addr_q    <= {ADDR_WIDTH{1'b0}};
      remain_q      <= {LEN_WIDTH{1'b0}};
      err_q         <= 1'b0;
      outstanding_q <= {OUT_W{1'b0}};
      beat_cnt_q    <= {SIZE_WIDTH{1'b0}};
      wreq_valid_q  <= 1'b0;
      wreq_addr_q   <= {ADDR_WIDTH{1'b0}};
      wreq_size_q   <= {SIZE_WIDTH{1'b0}};
      done_valid_q  <= 1'b0;
      done_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remain_q      <= remain_d;
      err_q         <= err_d;
      outstanding_q <= outstanding_d;
      beat_cnt_q    <= beat_cnt_d;
      wreq_valid_q  <= wreq_valid_d;
      wreq_addr_q   <= wreq_addr_d;
      wreq_size_q   <= wreq_size_d;
      done_valid_q  <= (state_q == S_DONE);
      done_err_q    <= (state_q == S_DONE) & err_q;
    end
  end

endmodule

// File: tb/tb_ddr_write_splitter.sv
// Self-checking bench for ddr_write_splitter: a table of jobs with hand-computed
// chunk requests, plus hand-written zero-length and reset-mid-data sequences.
module tb_ddr_write_splitter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_addr;
  logic [31:0] job_len;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        done_valid;
  logic        done_err;
  logic        ddr_wreq_valid;
  logic        ddr_wreq_ready;
  logic [31:0] ddr_wreq_addr;
  logic [15:0] ddr_wreq_size;
  logic        ddr_wdata_valid;
  logic        ddr_wdata_ready;
  logic        ddr_wdata_last;
  logic [63:0] ddr_wdata;
  logic        ddr_wresp_valid;
  logic [1:0]  ddr_wresp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ddr_write_splitter dut (
    .clk            (clk),
    .rstn           (rstn),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_addr       (job_addr),
    .job_len        (job_len),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .done_valid     (done_valid),
    .done_err       (done_err),
    .ddr_wreq_valid (ddr_wreq_valid),
    .ddr_wreq_ready (ddr_wreq_ready),
    .ddr_wreq_addr  (ddr_wreq_addr),
    .ddr_wreq_size  (ddr_wreq_size),
    .ddr_wdata_valid(ddr_wdata_valid),
    .ddr_wdata_ready(ddr_wdata_ready),
    .ddr_wdata_last (ddr_wdata_last),
    .ddr_wdata      (ddr_wdata),
    .ddr_wresp_valid(ddr_wresp_valid),
    .ddr_wresp      (ddr_wresp)
  );

  typedef struct {
    logic [31:0]      addr;
    logic [31:0]      len;
    int               n;      // expected number of chunk requests
    int               bad;    // index of the response returned as error, -1 for none
    bit               derr;   // expected done_err
    bit               rrdy;   // random ready on request and data channels
    bit               coin;   // first response coincides with the second request handshake
    bit               hold;   // withhold responses until 4 chunks are done
    logic [4:0][31:0] ca;     // expected chunk addresses, index 0 first
    logic [4:0][31:0] cs;     // expected chunk sizes
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] l, input int n,
                              input int bad, input bit derr, input bit rrdy, input bit coin,
                              input bit hold, input logic [4:0][31:0] ca,
                              input logic [4:0][31:0] cs);
    vec_t v;
    v.addr = a; v.len = l; v.n = n; v.bad = bad; v.derr = derr;
    v.rrdy = rrdy; v.coin = coin; v.hold = hold; v.ca = ca; v.cs = cs;
    return v;
  endfunction

  function automatic logic [63:0] pat(input int id, input int b);
    return {8'hD5, 8'(id), 16'h0000, 32'(b)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    job_valid = 1'b0; job_addr = 32'h0; job_len = 32'h0;
    in_valid = 1'b0; in_data = 64'h0;
    ddr_wreq_ready = 1'b0; ddr_wdata_ready = 1'b0;
    ddr_wresp_valid = 1'b0; ddr_wresp = 2'd0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_job_ready"},  64'(job_ready),       64'd1);
    chk({tag, "_in_ready"},   64'(in_ready),        64'd0);
    chk({tag, "_wreq_valid"}, 64'(ddr_wreq_valid),  64'd0);
    chk({tag, "_wreq_addr"},  64'(ddr_wreq_addr),   64'd0);
    chk({tag, "_wreq_size"},  64'(ddr_wreq_size),   64'd0);
    chk({tag, "_done_valid"}, 64'(done_valid),      64'd0);
    chk({tag, "_done_err"},   64'(done_err),        64'd0);
    chk({tag, "_wdata_valid"},64'(ddr_wdata_valid), 64'd0);
    chk({tag, "_wdata_last"}, 64'(ddr_wdata_last),  64'd0);
  endtask

  // Drives one job end to end, acting as data source and DDR slave.
  task automatic run_job(input vec_t v, input int id);
    int reqs = 0, beats_total = 0, beat_in = 0, pend = 0, resp_sent = 0;
    int chunks_done = 0, idle = 0, first_resp_cyc = -1;
    bit accepted = 0, done = 0, released, coin_chk = 0, exp_last;
    logic [31:0] csize = 32'd8;
    released = !v.hold;
    for (int cyc = 0; cyc < 30000 && !done; cyc++) begin
      @(negedge clk);
      if (coin_chk) begin
        chk("coin_outstanding", 64'(dut.outstanding_q), 64'd1);
        coin_chk = 0;
      end
      job_valid = !accepted; job_addr = v.addr; job_len = v.len;
      in_valid = 1'b1; in_data = pat(id, beats_total);
      ddr_wreq_ready  = v.rrdy ? 1'($urandom_range(0, 1)) : 1'b1;
      ddr_wdata_ready = v.rrdy ? 1'($urandom_range(0, 1)) : 1'b1;
      ddr_wresp_valid = 1'b0; ddr_wresp = 2'd0;
      if (pend > 0 && released &&
          (!v.coin || resp_sent != 0 || (ddr_wreq_valid && ddr_wreq_ready))) begin
        ddr_wresp_valid = 1'b1;
        ddr_wresp = (resp_sent == v.bad) ? 2'd2 : 2'd0;
        if (v.coin && resp_sent == 0) coin_chk = 1;
        if (first_resp_cyc < 0) first_resp_cyc = cyc;
        pend--; resp_sent++;
      end
      #1;
      if (job_valid && job_ready) accepted = 1;
      if (ddr_wreq_valid && ddr_wreq_ready) begin
        if (reqs < v.n) begin
          chk("req_addr", 64'(ddr_wreq_addr), 64'(v.ca[reqs]));
          chk("req_size", 64'(ddr_wreq_size), 64'(v.cs[reqs]));
          csize = v.cs[reqs];
        end else begin
          chk("req_excess", 64'(reqs + 1), 64'(v.n));
          csize = 32'(ddr_wreq_size);
        end
        if (v.hold && reqs == 4)
          chk("req5_after_resp", 64'(first_resp_cyc >= 0 && cyc >= first_resp_cyc + 2), 64'd1);
        reqs++;
      end
      if (ddr_wdata_valid && ddr_wdata_ready) begin
        chk("wdata", ddr_wdata, pat(id, beats_total));
        exp_last = (beat_in == int'(csize / 8) - 1);
        chk("wlast", 64'(ddr_wdata_last), 64'(exp_last));
        beats_total++;
        if (exp_last) begin
          beat_in = 0; pend++; chunks_done++;
        end else begin
          beat_in++;
        end
      end
      if (v.hold && !released && chunks_done == 4) begin
        chk("hold_no_req", 64'(ddr_wreq_valid), 64'd0);
        idle++;
        if (idle == 8) begin
          chk("hold_req_count", 64'(reqs), 64'd4);
          released = 1;
        end
      end
      if (done_valid) begin
        chk("done_err", 64'(done_err), 64'(v.derr));
        chk("req_total", 64'(reqs), 64'(v.n));
        chk("beat_total", 64'(beats_total), 64'(v.len / 8));
        done = 1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout job %0d: done_valid not seen, requests=%0d beats=%0d", id, reqs, beats_total);
    end
    idle_in();
  endtask

  initial begin
    int nb;
    bit acc;
    // addr, len, n, bad, derr, rrdy, coin, hold, {ca4..ca0}, {cs4..cs0}
    vecs[0] = mk(32'h1000_0000, 32'd256, 1, -1, 1'b0, 1'b0, 1'b0, 1'b0,
                 {32'h0, 32'h0, 32'h0, 32'h0, 32'h1000_0000},
                 {32'h0, 32'h0, 32'h0, 32'h0, 32'd256});
    vecs[1] = mk(32'h0000_0F00, 32'h300, 2, -1, 1'b0, 1'b0, 1'b0, 1'b0,
                 {32'h0, 32'h0, 32'h0, 32'h1000, 32'h0F00},
                 {32'h0, 32'h0, 32'h0, 32'h200, 32'h100});
    vecs[2] = mk(32'h0000_0000, 32'h3000, 3, 1, 1'b1, 1'b0, 1'b0, 1'b0,
                 {32'h0, 32'h0, 32'h2000, 32'h1000, 32'h0},
                 {32'h0, 32'h0, 32'h1000, 32'h1000, 32'h1000});
    vecs[3] = mk(32'h2000_0800, 32'h1000, 2, -1, 1'b0, 1'b0, 1'b0, 1'b0,
                 {32'h0, 32'h0, 32'h0, 32'h2000_1000, 32'h2000_0800},
                 {32'h0, 32'h0, 32'h0, 32'h800, 32'h800});
    vecs[4] = mk(32'h3000_0FF8, 32'd16, 2, -1, 1'b0, 1'b0, 1'b1, 1'b0,
                 {32'h0, 32'h0, 32'h0, 32'h3000_1000, 32'h3000_0FF8},
                 {32'h0, 32'h0, 32'h0, 32'd8, 32'd8});
    vecs[5] = mk(32'h5000_0010, 32'h40, 1, -1, 1'b0, 1'b1, 1'b0, 1'b0,
                 {32'h0, 32'h0, 32'h0, 32'h0, 32'h5000_0010},
                 {32'h0, 32'h0, 32'h0, 32'h0, 32'h40});
    vecs[6] = mk(32'h4000_0000, 32'h5000, 5, -1, 1'b0, 1'b1, 1'b0, 1'b1,
                 {32'h4000_4000, 32'h4000_3000, 32'h4000_2000, 32'h4000_1000, 32'h4000_0000},
                 {32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000});

    idle_in();
    rstn = 1'b0;
    @(negedge clk);
    #1;
    chk_reset("por");
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 7; i++) run_job(vecs[i], i);

    // Zero-length job: done two cycles after the handshake, no request.
    @(negedge clk);
    job_valid = 1'b1; job_addr = 32'h0123_0000; job_len = 32'd0;
    #1;
    chk("zl_job_ready", 64'(job_ready), 64'd1);
    @(negedge clk);
    job_valid = 1'b0;
    #1;
    chk("zl_done_c1", 64'(done_valid), 64'd0);
    chk("zl_wreq_c1", 64'(ddr_wreq_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("zl_done_c2", 64'(done_valid), 64'd1);
    chk("zl_err_c2", 64'(done_err), 64'd0);
    chk("zl_wreq_c2", 64'(ddr_wreq_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("zl_done_c3", 64'(done_valid), 64'd0);

    // Reset in the middle of the data phase after 10 beats.
    nb = 0; acc = 0;
    for (int c = 0; c < 200 && nb < 10; c++) begin
      @(negedge clk);
      job_valid = !acc; job_addr = 32'h1000_0000; job_len = 32'd256;
      ddr_wreq_ready = 1'b1; ddr_wdata_ready = 1'b1;
      in_valid = 1'b1; in_data = pat(8, nb);
      #1;
      if (job_valid && job_ready) acc = 1;
      if (ddr_wdata_valid && ddr_wdata_ready) nb++;
    end
    chk("rst_beats_reached", 64'(nb), 64'd10);
    @(negedge clk);
    job_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    idle_in();
    @(negedge clk);
    rstn = 1'b1;
    // Late error response after reset must be ignored.
    @(negedge clk);
    ddr_wresp_valid = 1'b1; ddr_wresp = 2'd2;
    @(negedge clk);
    ddr_wresp_valid = 1'b0; ddr_wresp = 2'd0;
    #1;
    chk("late_resp_outstanding", 64'(dut.outstanding_q), 64'd0);
    chk("late_resp_err", 64'(dut.err_q), 64'd0);
    run_job(vecs[0], 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr_write_splitter.md
# ddr_write_splitter

- Upstream feeder of the DataMover S2MM write adapter.
- Accepts one arbitrary-length DDR write job (start address, byte length) plus its data stream.
- Splits the job into boundary-aligned chunks, issuing one `ddr_wreq` per chunk and forwarding data with `ddr_wdata_last` on each chunk's final beat.
- Counts outstanding write responses and reports one completion pulse with a sticky error flag per job.

## Interface
- `DATA_WIDTH`, 64: data beat width in bits; bytes per beat `BPB = DATA_WIDTH/8`.
- `ADDR_WIDTH`, 32: byte address width.
- `SIZE_WIDTH`, 16: width of `ddr_wreq_size`; must satisfy `CHUNK_BYTES < 2^SIZE_WIDTH`.
- `LEN_WIDTH`, 32: width of job byte length.
- `CHUNK_BYTES`, 4096: maximum chunk size and boundary; power of two, multiple of `BPB`.
- `MAX_OUTSTANDING`, 4: maximum chunks requested but not yet responded.

Ports:
- `clk`  in  1  single clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `job_valid`  in  1  job command valid.
- `job_ready`  out  1  job accepted when high with `job_valid`.
- `job_addr`  in  ADDR_WIDTH  start byte address, `BPB`-aligned.
- `job_len`  in  LEN_WIDTH  byte count, multiple of `BPB`.
- `in_valid` / `in_ready`  in/out  1  job data handshake.
- `in_data`  in  DATA_WIDTH  job data.
- `done_valid`  out  1  one-cycle job completion pulse.
- `done_err`  out  1  valid with `done_valid`; 1 if any chunk response was non-OKAY.
- `ddr_wreq_valid` / `ddr_wreq_ready`  out/in  1  chunk request handshake.
- `ddr_wreq_addr`  out  ADDR_WIDTH  chunk address.
- `ddr_wreq_size`  out  SIZE_WIDTH  chunk bytes.
- `ddr_wdata_valid` / `ddr_wdata_ready`  out/in  1  chunk data handshake.
- `ddr_wdata_last`  out  1  final beat of chunk.
- `ddr_wdata`  out  DATA_WIDTH  chunk data.
- `ddr_wresp_valid`  in  1  one-cycle response pulse, no ready; one per chunk.
- `ddr_wresp`  in  2  0 = OKAY, otherwise error.

## Operation
- **States:** IDLE, REQ, DATA, DRAIN, DONE. Reset state is IDLE.
- **IDLE:**
  - `job_ready=1`.
  - On handshake, register `cur_addr=job_addr`, `remain=job_len`, clear `err`.
  - If `job_len==0`, go to DONE; else go to REQ.
- **REQ:** chunk size `csz = min(remain, CHUNK_BYTES - (cur_addr & (CHUNK_BYTES-1)))`.
  - `csz` is registered on entry, and `ddr_wreq_valid` is registered high with `ddr_wreq_addr=cur_addr`, `ddr_wreq_size=csz`.
  - `ddr_wreq_valid` is held stable until `ddr_wreq_ready`.
  - `ddr_wreq_valid` is not asserted while `outstanding==MAX_OUTSTANDING`.
  - On handshake: `outstanding++`, `beats=csz/BPB`, `beat_cnt=0`, go to DATA.
- **DATA:** combinational pass-through of data and handshake.
  - `ddr_wdata_valid=in_valid`, `in_ready=ddr_wdata_ready`, `ddr_wdata=in_data`.
  - `ddr_wdata_last = (beat_cnt==beats-1)`.
  - On each beat handshake, `beat_cnt++`.
  - On the last-beat handshake: `cur_addr+=csz`, `remain-=csz`; if `remain` becomes 0, go to DRAIN, else go to REQ.
  - Outside DATA, `in_ready=0` and `ddr_wdata_valid=0`.
- **DRAIN:** wait for `outstanding==0`, then go to DONE.
- **DONE:** `done_valid=1` and `done_err=err` for exactly one cycle, then go to IDLE.
- **Responses:** accepted in every state.
  - Each `ddr_wresp_valid` pulse decrements `outstanding`.
  - A pulse with `ddr_wresp!=0` sets `err` (sticky until the next job accept).
  - Request handshake and response in the same cycle: net `outstanding` unchanged.
  - A response with `outstanding==0` is ignored: no underflow, `err` unchanged.
- **Arithmetic:** `remain` and `cur_addr` use full `LEN_WIDTH`/`ADDR_WIDTH` modulo arithmetic. An address wrap past `2^ADDR_WIDTH` is not detected.
- **Input contract:** unaligned addresses or lengths are outside contract; low `log2(BPB)` bits are ignored.

## Timing
- **Reset values:** `ddr_wreq_valid=0`, `ddr_wreq_addr=0`, `ddr_wreq_size=0`, `done_valid=0`, `done_err=0`, `ddr_wdata_valid=0`, `ddr_wdata_last=0`, `in_ready=0`, `job_ready=1` (state IDLE).
- **Job to first request:** job handshake in cycle N gives `ddr_wreq_valid` high in N+1.
- **Chunk to next request:** last-beat handshake in cycle M gives the next `ddr_wreq_valid` no earlier than M+1.
- **Request to data:** request handshake in cycle K makes DATA active from K+1.
- **Data path:** zero added latency; throughput is one beat per cycle.
- **Completion:** final response in cycle R (with DATA complete) gives DRAIN exit at R+1 and `done_valid` at R+2.
- **Zero-length job:** `done_valid` two cycles after the job handshake.
- **Reset mid-job:** all state, counters, and `err` clear immediately. No completion is reported. Late responses after reset are ignored per the underflow rule.

## Test plan
- **Aligned single chunk:** `addr=0x1000_0000`, `len=256` → one request (addr 0x1000_0000, size 256); 32 beats with `last` on beat 32; response OKAY → `done_valid` with `done_err=0`.
- **Boundary split:** `addr=0x0000_0F00`, `len=0x300` → request (0x0F00, 0x100) with `last` on beat 32, then request (0x1000, 0x200) with `last` on beat 64.
- **Outstanding limit:** `len=5*4096` aligned, responses withheld → exactly 4 requests; 5th `ddr_wreq_valid` only after the first response pulse. `ddr_wdata_ready` toggled randomly → data order intact.
- **Error:** 3 chunks with the second response `ddr_wresp=2` → `done_err=1`; the next job reports `done_err=0`.
- **Zero length / simultaneous events:** `len=0` → `done_valid` two cycles later, no request. Response pulse coincident with a request handshake → `outstanding` unchanged.
- **Reset mid-DATA:** assert `rstn=0` after beat 10 → all outputs at reset values; a new job after reset completes normally.
